// File: rtl/crc32_fcs_chk16.sv
// rtl/crc32_fcs_chk16.sv - receive-side Ethernet FCS checker for the 16-bit MAC datapath
//
// crc32_d16s: combinational CRC-32 advance by 16 data bits, MSB-first.
//   seed [31:0] in   register value before the step
//   data [15:0] in   data bits, bit 15 shifted in first
//   crc  [31:0] out  register value after the step
//
// crc32_fcs_chk16: accumulates CRC-32 over each frame (FCS included), forwards
// the word stream one cycle late and reports per-frame status with out_eop.
//   clk, rst_n                       clock, synchronous active-low reset
//   in_valid/in_sop/in_eop/in_odd    input word qualifiers
//   in_data [15:0]                   input word, first-on-wire byte in [15:8]
//   cnt_clr                          clears both frame counters
//   out_valid/out_sop/out_eop/out_odd, out_data [15:0]
//                                    forwarded word, one cycle latency
//   chk_done                         one-cycle status pulse
//   chk_ok/chk_len/chk_runt/chk_proto_err
//                                    frame status, zero unless chk_done
//   cnt_good/cnt_bad [15:0]          saturating frame counters

module crc32_d16s (
  input  logic [31:0] seed,
  input  logic [15:0] data,
  output logic [31:0] crc
);

  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  always_comb begin
    crc = seed;
    for (int i = 15; i >= 0; i--) begin
      crc = {crc[30:0], 1'b0} ^ ({32{crc[31] ^ data[i]}} & POLY);
    end
  end

endmodule

module crc32_fcs_chk16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic        in_odd,
  input  logic [15:0] in_data,
  input  logic        cnt_clr,
  output logic        out_valid,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_odd,
  output logic [15:0] out_data,
  output logic        chk_done,
  output logic        chk_ok,
  output logic [15:0] chk_len,
  output logic        chk_runt,
  output logic        chk_proto_err,
  output logic [15:0] cnt_good,
  output logic [15:0] cnt_bad
);

  localparam logic [31:0] POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] RESIDUE = 32'hC704_DD7B;

  typedef enum logic {IDLE, FRAME} state_t;

  state_t      state_q, state_d;
  logic [31:0] crc_q;
  logic [15:0] len_q;

  logic        accept, abort, last, odd_last;
  logic [31:0] seed, crc16, crc8, crc_d;
  logic [16:0] len_sum;
  logic [15:0] len_base, len_d, len_st;
  logic        done_d, ok_d, proto_d, runt_d;
  logic        good_inc;
  logic [1:0]  bad_inc;
  logic [16:0] good_sum, bad_sum;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    for (int i = 0; i < 8; i++) rev8[i] = b[7-i];
  endfunction

  // Words outside a frame are dropped unless they open a new one.
  assign accept   = in_valid & (in_sop | (state_q == FRAME));
  assign abort    = in_valid & in_sop & (state_q == FRAME);
  assign last     = accept & in_eop;
  assign odd_last = last & in_odd;

  assign seed = in_sop ? 32'hFFFF_FFFF : crc_q;

  crc32_d16s u_crc16 (
    .seed (seed),
    .data ({rev8(in_data[15:8]), rev8(in_data[7:0])}),
    .crc  (crc16)
  );

  // Single-byte step for the odd trailing byte of a frame.
  always_comb begin
    logic [7:0] b;
    b    = rev8(in_data[15:8]);
    crc8 = seed;
    for (int i = 7; i >= 0; i--) begin
      crc8 = {crc8[30:0], 1'b0} ^ ({32{crc8[31] ^ b[i]}} & POLY);
    end
  end

  assign crc_d = odd_last ? crc8 : crc16;

  assign len_base = in_sop ? 16'd0 : len_q;
  assign len_sum  = {1'b0, len_base} + (odd_last ? 17'd1 : 17'd2);
  assign len_d    = len_sum[16] ? 16'hFFFF : len_sum[15:0];

  // An eop on the aborting word supersedes the abort report; the aborted
  // frame is still charged to cnt_bad through bad_inc.
  assign done_d   = last | abort;
  assign ok_d     = last & (crc_d == RESIDUE);
  assign proto_d  = abort & ~last;
  assign len_st   = last ? len_d : len_q;
  assign runt_d   = done_d & (len_st < 16'd64);
  assign good_inc = ok_d;
  assign bad_inc  = {1'b0, last & ~ok_d} + {1'b0, abort};
  assign good_sum = {1'b0, cnt_good} + {16'd0, good_inc};
  assign bad_sum  = {1'b0, cnt_bad} + {15'd0, bad_inc};

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) state_d = in_eop ? IDLE : FRAME;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_q         <= 32'hFFFF_FFFF;
      len_q         <= '0;
      out_valid     <= 1'b0;
      out_sop       <= 1'b0;
      out_eop       <= 1'b0;
      out_odd       <= 1'b0;
      out_data      <= '0;
      chk_done      <= 1'b0;
      chk_ok        <= 1'b0;
      chk_len       <= '0;
      chk_runt      <= 1'b0;
      chk_proto_err <= 1'b0;
      cnt_good      <= '0;
      cnt_bad       <= '0;
    end else begin
      if (accept) begin
        crc_q <= crc_d;
        len_q <= len_d;
      end
      out_valid     <= accept;
      out_sop       <= accept & in_sop;
      out_eop       <= last;
      out_odd       <= odd_last;
      out_data      <= accept ? in_data : 16'd0;
      chk_done      <= done_d;
      chk_ok        <= ok_d;
      chk_len       <= done_d ? len_st : 16'd0;
      chk_runt      <= runt_d;
      chk_proto_err <= proto_d;
      if (cnt_clr) begin
        cnt_good <= '0;
        cnt_bad  <= '0;
      end else begin
        cnt_good <= good_sum[16] ? 16'hFFFF : good_sum[15:0];
        cnt_bad  <= bad_sum[16]  ? 16'hFFFF : bad_sum[15:0];
      end
    end
  end

endmodule
